sfr_bus_arb: RTL and testbench
==============================

Name: sfr_bus_arb

Overview:
- Two-master arbiter sharing the single 32-bit split-transaction slave port of the tile SFR block.
- Masters are the local core data port (m0) and the debug/host port (m1).
- Round-robin arbitration; at most one read outstanding at a time.
- Read responses are routed back to the issuing master. A response timeout guards against a slave that never responds.

Parameters:
RESP_TIMEOUT, 16, cycles to wait for read response after address handshake; 0 disables timeout
TIMEOUT_RDATA, 32'hBADC0DE0, rdata returned on timed-out read

Ports:
clk_i  input  1  clock
rst_i  input  1  asynchronous active-high reset
mN_req_i  input  1  master N request (N=0,1), held until ack
mN_we_i  input  1  master N write enable
mN_addr_bi  input  32  master N address
mN_be_bi  input  4  master N byte enables
mN_wdata_bi  input  32  master N write data
mN_ack_o  output  1  master N request accepted
mN_resp_o  output  1  master N read response valid (1-cycle pulse)
mN_rdata_bo  output  32  master N read data
s_req_o  output  1  slave request
s_we_o  output  1  slave write enable
s_addr_bo  output  32  slave address
s_be_bo  output  4  slave byte enables
s_wdata_bo  output  32  slave write data
s_ack_i  input  1  slave accept
s_resp_i  input  1  slave read response
s_rdata_bi  input  32  slave read data
timeout_o  output  1  1-cycle pulse on read timeout

Behaviour:

Reset (rst_i asynchronous):
- state=IDLE, rr_ptr=0 (m0 has priority), lock=0, timer=0, timeout_o=0.
- With no requests: s_req_o=0, all ack/resp=0, rdata outputs 0.

State machine:
- IDLE:
  - Grant select, combinational:
    - lock=1: keep locked master.
    - else only one request: grant that master.
    - else both: grant master rr_ptr.
  - Selected master's req/we/addr/be/wdata muxed combinationally onto s_*.
  - mN_ack_o = grant_N & s_ack_i; other ack=0.
  - Handshake (s_req_o & s_ack_i):
    - rr_ptr <= ~granted index.
    - lock <= 0.
    - Write: stay IDLE, so back-to-back handshakes are allowed every cycle.
    - Read: owner <= index, timer <= 0, -> RD_WAIT.
  - Request pending without ack: lock <= 1 on current grant. No re-arbitration until handshake.
- RD_WAIT:
  - s_req_o=0; all mN_ack_o=0.
  - mOWNER_resp_o = s_resp_i; mOWNER_rdata_bo = s_rdata_bi (combinational); non-owner resp=0.
  - s_resp_i=1: -> IDLE. A new grant is possible the next cycle, not the same cycle.
  - Else timer increments each cycle. When RESP_TIMEOUT!=0 and timer==RESP_TIMEOUT-1 with no resp:
    - owner resp_o=1, rdata=TIMEOUT_RDATA, timeout_o=1 for that cycle;
    - -> IDLE.
  - Response and timeout in the same cycle: the real response wins, no timeout_o.

Widths and rules:
- timer width $clog2(RESP_TIMEOUT+1), minimum 1; no wrap (RESP_TIMEOUT=0 freezes timer at 0).
- s_resp_i in IDLE (late or spurious) is dropped: not forwarded, no side effects.
- mN_rdata_bo = 0 when that master's resp_o=0.
- Reset mid-RD_WAIT: no response delivered; immediately IDLE with m0 priority.
- Write transactions never generate resp.
- Master withdrawing req before ack is illegal; behaviour is undefined but must not hang the FSM.

Test Plan:
- Read, normal response: m0 read addr 0x0; slave acks same cycle, s_resp_i after 3 cycles with 0xDEADBEEF -> m0_resp_o one cycle with m0_rdata_bo=0xDEADBEEF; m1_resp_o stays 0.
- Write contention: after reset, m0 and m1 both write (0x4 data 1, 0xC data 0x55) in the same cycle -> m0 acked cycle 0, m1 acked cycle 1. Next simultaneous contention -> m1 acked first.
- Read blocking: m1 read outstanding, m0 raises write during RD_WAIT -> m0_ack_o stays 0 until the cycle after s_resp_i; m1_resp_o carries the data, m0_resp_o=0.
- Timeout: RESP_TIMEOUT=16, m0 read, slave never responds -> 16 cycles after handshake m0_resp_o=1, rdata=0xBADC0DE0, timeout_o=1 for 1 cycle. A later s_resp_i is ignored (m0_resp_o=0).
- Grant lock: both request, s_ack_i held 0 for 2 cycles -> s_addr_bo stays on m0 throughout; m0 acked when s_ack_i rises; m1 granted next cycle.
- Reset mid-read: assert rst_i during RD_WAIT, then deliver s_resp_i after release -> no mN_resp_o pulse; next contention grants m0 first.

Source files
------------

// File: rtl/sfr_bus_arb.sv
// Two-master round-robin arbiter in front of the tile SFR split-transaction slave port.
// Allows one outstanding read at a time. The read response is routed back to the issuing master, with a response timeout as backstop.
module sfr_bus_arb #(
  parameter int unsigned RESP_TIMEOUT  = 16,
  parameter logic [31:0] TIMEOUT_RDATA = 32'hBADC0DE0
) (
  input  logic        clk_i,
  input  logic        rst_i,

  input  logic        m0_req_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_bi,
  input  logic [3:0]  m0_be_bi,
  input  logic [31:0] m0_wdata_bi,
  output logic        m0_ack_o,
  output logic        m0_resp_o,
  output logic [31:0] m0_rdata_bo,

  input  logic        m1_req_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_bi,
  input  logic [3:0]  m1_be_bi,
  input  logic [31:0] m1_wdata_bi,
  output logic        m1_ack_o,
  output logic        m1_resp_o,
  output logic [31:0] m1_rdata_bo,

  output logic        s_req_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_bo,
  output logic [3:0]  s_be_bo,
  output logic [31:0] s_wdata_bo,
  input  logic        s_ack_i,
  input  logic        s_resp_i,
  input  logic [31:0] s_rdata_bi,

  output logic        timeout_o
);

  localparam int unsigned TW = (RESP_TIMEOUT == 0) ? 1 : $clog2(RESP_TIMEOUT + 1);
  localparam bit          T_EN = (RESP_TIMEOUT != 0);
  localparam logic [TW-1:0] T_LAST = TW'((RESP_TIMEOUT == 0) ? 0 : RESP_TIMEOUT - 1);
  localparam logic [TW-1:0] T_MAX  = TW'(RESP_TIMEOUT);

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  state_t        state, state_nxt;
  logic          rr_ptr;
  logic          lock;
  logic          lock_idx;
  logic          owner;
  logic [TW-1:0] timer;

  logic          grant_idx;
  logic          grant_req;
  logic          handshake;
  logic          timeout_hit;
  logic          resp_evt;
  logic [31:0]   resp_data;

  // A pending request without an ack stays locked. This prevents the slave from seeing the request change under it.
  always_comb begin
    grant_idx = rr_ptr;
    if (lock)
      grant_idx = lock_idx;
    else if (m0_req_i && !m1_req_i)
      grant_idx = 1'b0;
    else if (m1_req_i && !m0_req_i)
      grant_idx = 1'b1;
    grant_req = grant_idx ? m1_req_i : m0_req_i;
  end

  assign s_req_o    = (state == IDLE) && grant_req;
  assign s_we_o     = grant_idx ? m1_we_i     : m0_we_i;
  assign s_addr_bo  = grant_idx ? m1_addr_bi  : m0_addr_bi;
  assign s_be_bo    = grant_idx ? m1_be_bi    : m0_be_bi;
  assign s_wdata_bo = grant_idx ? m1_wdata_bi : m0_wdata_bi;

  assign handshake = s_req_o && s_ack_i;
  assign m0_ack_o  = handshake && !grant_idx;
  assign m1_ack_o  = handshake &&  grant_idx;

  // A real response in the final timer cycle takes precedence over the timeout.
  assign timeout_hit = T_EN && (state == RD_WAIT) && (timer == T_LAST) && !s_resp_i;
  assign resp_evt    = (state == RD_WAIT) && (s_resp_i || timeout_hit);
  assign resp_data   = s_resp_i ? s_rdata_bi : TIMEOUT_RDATA;

  assign m0_resp_o   = resp_evt && !owner;
  assign m1_resp_o   = resp_evt &&  owner;
  assign m0_rdata_bo = m0_resp_o ? resp_data : 32'h0;
  assign m1_rdata_bo = m1_resp_o ? resp_data : 32'h0;
  assign timeout_o   = timeout_hit;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (handshake && !s_we_o) state_nxt = RD_WAIT;
      RD_WAIT: if (s_resp_i || timeout_hit) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  // Arbitration bookkeeping and response timer. The timer saturates instead of wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr   <= 1'b0;
      lock     <= 1'b0;
      lock_idx <= 1'b0;
      owner    <= 1'b0;
      timer    <= '0;
    end else if (state == IDLE) begin
      if (handshake) begin
        rr_ptr <= ~grant_idx;
        lock   <= 1'b0;
        if (!s_we_o) begin
          owner <= grant_idx;
          timer <= '0;
        end
      end else if (grant_req) begin
        lock     <= 1'b1;
        lock_idx <= grant_idx;
      end else begin
        lock <= 1'b0;
      end
    end else if (T_EN && !s_resp_i && !timeout_hit && (timer != T_MAX)) begin
      timer <= timer + 1'b1;
    end
  end

endmodule

// File: tb/tb_sfr_bus_arb.sv
// Directed bench for sfr_bus_arb.
// Expected read responses are queued when a read is issued and checked when a response pulse is due.
module tb_sfr_bus_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        m0_req_i = 0, m0_we_i = 0;
  logic [31:0] m0_addr_bi = 0, m0_wdata_bi = 0;
  logic [3:0]  m0_be_bi = 4'hF;
  logic        m1_req_i = 0, m1_we_i = 0;
  logic [31:0] m1_addr_bi = 0, m1_wdata_bi = 0;
  logic [3:0]  m1_be_bi = 4'hF;
  logic        s_ack_i = 0, s_resp_i = 0;
  logic [31:0] s_rdata_bi = 0;

  logic        m0_ack_o, m0_resp_o, m1_ack_o, m1_resp_o;
  logic [31:0] m0_rdata_bo, m1_rdata_bo;
  logic        s_req_o, s_we_o, timeout_o;
  logic [31:0] s_addr_bo, s_wdata_bo;
  logic [3:0]  s_be_bo;

  int compared   = 0;
  int mismatched = 0;

  typedef struct {
    int          master;
    logic [31:0] data;
    logic        to;
  } exp_resp_t;

  exp_resp_t sb[$];

  sfr_bus_arb #(.RESP_TIMEOUT(16), .TIMEOUT_RDATA(32'hBADC0DE0)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_req_i(m0_req_i), .m0_we_i(m0_we_i), .m0_addr_bi(m0_addr_bi), .m0_be_bi(m0_be_bi),
    .m0_wdata_bi(m0_wdata_bi), .m0_ack_o(m0_ack_o), .m0_resp_o(m0_resp_o), .m0_rdata_bo(m0_rdata_bo),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_addr_bi(m1_addr_bi), .m1_be_bi(m1_be_bi),
    .m1_wdata_bi(m1_wdata_bi), .m1_ack_o(m1_ack_o), .m1_resp_o(m1_resp_o), .m1_rdata_bo(m1_rdata_bo),
    .s_req_o(s_req_o), .s_we_o(s_we_o), .s_addr_bo(s_addr_bo), .s_be_bo(s_be_bo),
    .s_wdata_bo(s_wdata_bo), .s_ack_i(s_ack_i), .s_resp_i(s_resp_i), .s_rdata_bi(s_rdata_bi),
    .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input int m, input logic req, input logic we,
                               input logic [31:0] addr, input logic [31:0] wdata);
    if (m == 0) begin
      m0_req_i = req; m0_we_i = we; m0_addr_bi = addr; m0_wdata_bi = wdata;
    end else begin
      m1_req_i = req; m1_we_i = we; m1_addr_bi = addr; m1_wdata_bi = wdata;
    end
  endtask

  task automatic expectRead(input int m, input logic [31:0] data, input logic to);
    exp_resp_t e;
    e.master = m; e.data = data; e.to = to;
    sb.push_back(e);
  endtask

  // Pops the oldest expected response and compares it against the pulse seen this cycle.
  task automatic checkResp(input string tag);
    exp_resp_t e;
    if (sb.size() == 0) begin
      checkOutput({tag, "_sb_nonempty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      checkOutput({tag, "_m0_resp"}, {31'd0, m0_resp_o}, (e.master == 0) ? 32'd1 : 32'd0);
      checkOutput({tag, "_m1_resp"}, {31'd0, m1_resp_o}, (e.master == 1) ? 32'd1 : 32'd0);
      checkOutput({tag, "_rdata"}, (e.master == 0) ? m0_rdata_bo : m1_rdata_bo, e.data);
      checkOutput({tag, "_timeout"}, {31'd0, timeout_o}, {31'd0, e.to});
    end
  endtask

  task automatic checkQuiet(input string tag);
    checkOutput({tag, "_resps"}, {30'd0, m1_resp_o, m0_resp_o}, 32'd0);
    checkOutput({tag, "_rdata0"}, m0_rdata_bo, 32'd0);
    checkOutput({tag, "_rdata1"}, m1_rdata_bo, 32'd0);
    checkOutput({tag, "_timeout"}, {31'd0, timeout_o}, 32'd0);
  endtask

  task automatic pulseReset();
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
  endtask

  initial begin
    // reset state
    step();
    #1;
    checkOutput("rst_s_req", {31'd0, s_req_o}, 32'd0);
    checkOutput("rst_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    checkQuiet("rst");
    step();
    rst_i = 1'b0;
    step();

    // read with normal response after 3 cycles
    applyStimulus(0, 1, 0, 32'h0, 32'h0);
    s_ack_i = 1;
    #1;
    checkOutput("rd_s_req", {31'd0, s_req_o}, 32'd1);
    checkOutput("rd_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    checkOutput("rd_s_we", {31'd0, s_we_o}, 32'd0);
    expectRead(0, 32'hDEADBEEF, 1'b0);
    step();
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 0;
    #1;
    checkOutput("rdw_s_req", {31'd0, s_req_o}, 32'd0);
    checkQuiet("rdw1");
    step();
    step();
    s_resp_i = 1; s_rdata_bi = 32'hDEADBEEF;
    #1;
    checkResp("rd");
    step();
    s_resp_i = 0; s_rdata_bi = 32'h0;
    #1;
    checkQuiet("rd_after");

    // write contention from reset: m0 first, then round robin
    pulseReset();
    applyStimulus(0, 1, 1, 32'h4, 32'h1);
    applyStimulus(1, 1, 1, 32'hC, 32'h55);
    s_ack_i = 1;
    #1;
    checkOutput("wc0_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    checkOutput("wc0_m1_ack", {31'd0, m1_ack_o}, 32'd0);
    checkOutput("wc0_addr", s_addr_bo, 32'h4);
    checkOutput("wc0_wdata", s_wdata_bo, 32'h1);
    checkOutput("wc0_we", {31'd0, s_we_o}, 32'd1);
    step();
    applyStimulus(0, 1, 1, 32'h8, 32'h2);
    #1;
    checkOutput("wc1_m1_ack", {31'd0, m1_ack_o}, 32'd1);
    checkOutput("wc1_m0_ack", {31'd0, m0_ack_o}, 32'd0);
    checkOutput("wc1_addr", s_addr_bo, 32'hC);
    checkOutput("wc1_wdata", s_wdata_bo, 32'h55);
    step();
    applyStimulus(1, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("wc2_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    checkOutput("wc2_addr", s_addr_bo, 32'h8);
    step();
    applyStimulus(0, 1, 1, 32'h14, 32'h3);
    applyStimulus(1, 1, 1, 32'h18, 32'h4);
    #1;
    checkOutput("wc3_m1_first", {30'd0, m1_ack_o, m0_ack_o}, 32'd2);
    checkOutput("wc3_addr", s_addr_bo, 32'h18);
    checkQuiet("wc3");
    step();
    applyStimulus(1, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("wc4_m0", {30'd0, m1_ack_o, m0_ack_o}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 32'h0);

    // read blocking: m1 read outstanding, m0 write waits
    applyStimulus(1, 1, 0, 32'h10, 32'h0);
    #1;
    checkOutput("rb_m1_ack", {31'd0, m1_ack_o}, 32'd1);
    expectRead(1, 32'hCAFEF00D, 1'b0);
    step();
    applyStimulus(1, 0, 0, 32'h0, 32'h0);
    applyStimulus(0, 1, 1, 32'h20, 32'h77);
    #1;
    checkOutput("rb_w1_ack", {31'd0, m0_ack_o}, 32'd0);
    checkOutput("rb_w1_sreq", {31'd0, s_req_o}, 32'd0);
    step();
    #1;
    checkOutput("rb_w2_ack", {31'd0, m0_ack_o}, 32'd0);
    step();
    s_resp_i = 1; s_rdata_bi = 32'hCAFEF00D;
    #1;
    checkResp("rb");
    checkOutput("rb_resp_ack", {31'd0, m0_ack_o}, 32'd0);
    step();
    s_resp_i = 0; s_rdata_bi = 32'h0;
    #1;
    checkOutput("rb_after_ack", {31'd0, m0_ack_o}, 32'd1);
    checkOutput("rb_after_addr", s_addr_bo, 32'h20);
    step();
    applyStimulus(0, 0, 0, 32'h0, 32'h0);

    // timeout: slave never responds
    applyStimulus(0, 1, 0, 32'h30, 32'h0);
    #1;
    checkOutput("to_m0_ack", {31'd0, m0_ack_o}, 32'd1);
    expectRead(0, 32'hBADC0DE0, 1'b1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    s_ack_i = 0;
    for (int k = 1; k <= 16; k++) begin
      #1;
      if (k < 16) checkQuiet($sformatf("to_wait%0d", k));
      else        checkResp("to");
      step();
    end
    s_resp_i = 1; s_rdata_bi = 32'h12345678;
    #1;
    checkQuiet("to_late");
    step();
    s_resp_i = 0; s_rdata_bi = 32'h0;

    // grant lock: m0 held while slave stalls
    pulseReset();
    applyStimulus(0, 1, 1, 32'h40, 32'hA);
    applyStimulus(1, 1, 1, 32'h44, 32'hB);
    #1;
    checkOutput("lk0_addr", s_addr_bo, 32'h40);
    checkOutput("lk0_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
    step();
    #1;
    checkOutput("lk1_addr", s_addr_bo, 32'h40);
    step();
    s_ack_i = 1;
    #1;
    checkOutput("lk2_addr", s_addr_bo, 32'h40);
    checkOutput("lk2_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("lk3_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd2);
    checkOutput("lk3_addr", s_addr_bo, 32'h44);
    step();
    applyStimulus(1, 1, 1, 32'h4C, 32'hC);
    s_ack_i = 0;
    step();
    applyStimulus(0, 1, 1, 32'h48, 32'hD);
    #1;
    checkOutput("lk4_keep_m1", s_addr_bo, 32'h4C);
    step();
    s_ack_i = 1;
    #1;
    checkOutput("lk5_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd2);
    step();
    applyStimulus(1, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("lk6_acks", {30'd0, m1_ack_o, m0_ack_o}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 32'h0);

    // reset during RD_WAIT drops the pending response
    applyStimulus(1, 1, 0, 32'h50, 32'h0);
    #1;
    checkOutput("mr_m1_ack", {31'd0, m1_ack_o}, 32'd1);
    step();
    applyStimulus(1, 0, 0, 32'h0, 32'h0);
    s_ack_i = 0;
    step();
    rst_i = 1;
    #1;
    checkQuiet("mr_inrst");
    step();
    rst_i = 0;
    s_resp_i = 1; s_rdata_bi = 32'h11111111;
    #1;
    checkQuiet("mr_late");
    step();
    s_resp_i = 0; s_rdata_bi = 32'h0;
    applyStimulus(0, 1, 1, 32'h60, 32'h1);
    applyStimulus(1, 1, 1, 32'h64, 32'h2);
    s_ack_i = 1;
    #1;
    checkOutput("mr_prio", {30'd0, m1_ack_o, m0_ack_o}, 32'd1);
    step();
    applyStimulus(0, 0, 0, 32'h0, 32'h0);
    #1;
    checkOutput("mr_next", {30'd0, m1_ack_o, m0_ack_o}, 32'd2);
    step();
    applyStimulus(1, 0, 0, 32'h0, 32'h0);
    s_ack_i = 0;

    checkOutput("sb_drained", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
